// File: rtl/multi_input_counter.sv
// multi_input_counter
//   Counts qualified edges on CHANNELS asynchronous inputs while a gate
//   window is open. Each channel has its own synchroniser, edge detector,
//   saturating counter and sticky overflow flag. When the window closes,
//   all running counters are latched into a snapshot for the register bank.
//
// Ports
//   i_clk        system clock (only clock)
//   i_reset      synchronous, active-high reset
//   i_signal     asynchronous count inputs, bit n = channel n
//   i_gate       counting window, synchronous to i_clk
//   i_edge_mode  00 rising, 01 falling, 10 both, 11 none (captured per window)
//   o_live       running counters, channel n at [n*WIDTH +: WIDTH]
//   o_count      snapshot latched at gate end, same packing as o_live
//   o_overflow   sticky saturation flags belonging to the snapshot
//   o_valid      one-cycle pulse when o_count/o_overflow update
//   o_busy       high while a window is running
module multi_input_counter #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic [CHANNELS-1:0]          i_signal,
  input  logic                         i_gate,
  input  logic [1:0]                   i_edge_mode,
  output logic [CHANNELS*WIDTH-1:0]    o_live,
  output logic [CHANNELS*WIDTH-1:0]    o_count,
  output logic [CHANNELS-1:0]          o_overflow,
  output logic                         o_valid,
  output logic                         o_busy
);

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, state_next;

  logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
  logic [CHANNELS-1:0] prev_q;
  logic [1:0]          mode_q;
  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [CHANNELS-1:0] ovf_q;

  logic [CHANNELS-1:0] rise, fall;
  logic [CHANNELS-1:0] qual_start, qual_run;
  logic                start_win, run_win, end_win;

  function automatic logic [CHANNELS-1:0] qualify(
    input logic [1:0]          mode,
    input logic [CHANNELS-1:0] r,
    input logic [CHANNELS-1:0] f
  );
    case (mode)
      2'b00:   return r;
      2'b01:   return f;
      2'b10:   return r | f;
      default: return '0;
    endcase
  endfunction

  // Synchroniser runs regardless of the gate so edge history is valid
  // the moment a window opens.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= i_signal;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & prev_q;

  // The opening edge qualifies with the mode being captured, not the stale one.
  assign qual_start = qualify(i_edge_mode, rise, fall);
  assign qual_run   = qualify(mode_q, rise, fall);

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_win  = 1'b0;
    run_win    = 1'b0;
    end_win    = 1'b0;
    case (state)
      IDLE: begin
        if (i_gate) begin
          state_next = RUN;
          start_win  = 1'b1;
        end
      end
      RUN: begin
        if (i_gate) begin
          run_win = 1'b1;
        end else begin
          state_next = IDLE;
          end_win    = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned ch = 0; ch < CHANNELS; ch++) cnt_q[ch] <= '0;
      ovf_q      <= '0;
      mode_q     <= '0;
      o_count    <= '0;
      o_overflow <= '0;
      o_valid    <= 1'b0;
    end else begin
      o_valid <= end_win;
      if (start_win) begin
        mode_q <= i_edge_mode;
        ovf_q  <= '0;
        for (int unsigned ch = 0; ch < CHANNELS; ch++)
          cnt_q[ch] <= qual_start[ch] ? CNT_ONE : '0;
      end
      if (run_win) begin
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
          if (qual_run[ch]) begin
            if (&cnt_q[ch]) ovf_q[ch]  <= 1'b1;
            else            cnt_q[ch] <= cnt_q[ch] + CNT_ONE;
          end
        end
      end
      if (end_win) begin
        for (int unsigned ch = 0; ch < CHANNELS; ch++)
          o_count[ch*WIDTH +: WIDTH] <= cnt_q[ch];
        o_overflow <= ovf_q;
      end
    end
  end

  always_comb begin
    o_live = '0;
    for (int unsigned ch = 0; ch < CHANNELS; ch++)
      o_live[ch*WIDTH +: WIDTH] = cnt_q[ch];
  end

  assign o_busy = (state == RUN);

endmodule

// File: tb/tb_multi_input_counter.sv
// tb_multi_input_counter
//   Drives directed window scenarios and a randomized phase into a
//   4-channel, 8-bit, 3-stage-synchroniser counter and compares every
//   cycle against a cycle-level behavioural model of the counting rules.
module tb_multi_input_counter;

  localparam int unsigned CH   = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned S    = 3;
  localparam int unsigned MAXC = (1 << W) - 1;

  logic              i_clk;
  logic              i_reset;
  logic [CH-1:0]     i_signal;
  logic              i_gate;
  logic [1:0]        i_edge_mode;
  logic [CH*W-1:0]   o_live;
  logic [CH*W-1:0]   o_count;
  logic [CH-1:0]     o_overflow;
  logic              o_valid;
  logic              o_busy;

  multi_input_counter #(
    .CHANNELS   (CH),
    .WIDTH      (W),
    .SYNC_STAGES(S)
  ) u_dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_signal   (i_signal),
    .i_gate     (i_gate),
    .i_edge_mode(i_edge_mode),
    .o_live     (o_live),
    .o_count    (o_count),
    .o_overflow (o_overflow),
    .o_valid    (o_valid),
    .o_busy     (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: input history sampled at each clock edge; an input
  // sampled at edge t is seen as "current" by the edge detector at t+S.
  logic [CH-1:0] m_hist [0:S];
  bit            m_run;
  logic [1:0]    m_mode;
  int unsigned   m_cnt  [CH];
  int unsigned   m_snap [CH];
  logic [CH-1:0] m_flg, m_ovf;
  bit            m_valid;

  function automatic bit edge_hit(input logic [1:0] md, input bit r, input bit f);
    case (md)
      2'b00:   return r;
      2'b01:   return f;
      2'b10:   return r | f;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_edge();
    logic [CH-1:0] s, p;
    bit hit;
    if (i_reset) begin
      for (int j = 0; j <= S; j++) m_hist[j] = '0;
      m_run = 0; m_mode = 2'b00; m_flg = '0; m_ovf = '0; m_valid = 0;
      for (int c = 0; c < CH; c++) begin m_cnt[c] = 0; m_snap[c] = 0; end
    end else begin
      s = m_hist[S-1];
      p = m_hist[S];
      for (int j = S; j >= 1; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = i_signal;
      m_valid = 0;
      if (!m_run) begin
        if (i_gate) begin
          m_run  = 1;
          m_mode = i_edge_mode;
          m_flg  = '0;
          for (int c = 0; c < CH; c++)
            m_cnt[c] = edge_hit(i_edge_mode, s[c] & ~p[c], ~s[c] & p[c]) ? 1 : 0;
        end
      end else if (i_gate) begin
        for (int c = 0; c < CH; c++) begin
          hit = edge_hit(m_mode, s[c] & ~p[c], ~s[c] & p[c]);
          if (hit) begin
            if (m_cnt[c] == MAXC) m_flg[c] = 1'b1;
            else                  m_cnt[c] = m_cnt[c] + 1;
          end
        end
      end else begin
        m_snap  = m_cnt;
        m_ovf   = m_flg;
        m_valid = 1;
        m_run   = 0;
      end
    end
  endtask

  task automatic step();
    logic [CH*W-1:0] e_live, e_count;
    @(posedge i_clk);
    model_edge();
    #1;
    for (int c = 0; c < CH; c++) begin
      e_live[c*W +: W]  = m_cnt[c][W-1:0];
      e_count[c*W +: W] = m_snap[c][W-1:0];
    end
    check("live",     o_live,     e_live);
    check("count",    o_count,    e_count);
    check("overflow", o_overflow, m_ovf);
    check("valid",    o_valid,    m_valid);
    check("busy",     o_busy,     m_run);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pulses(input logic [CH-1:0] mask, input int n, input int hi,
                        input int lo, input bit scramble);
    repeat (n) begin
      i_signal = i_signal | mask;
      repeat (hi) begin step(); if (scramble) i_edge_mode = 2'($urandom); end
      i_signal = i_signal & ~mask;
      repeat (lo) begin step(); if (scramble) i_edge_mode = 2'($urandom); end
    end
  endtask

  task automatic open_gate(input logic [1:0] md);
    i_gate = 1'b1;
    i_edge_mode = md;
    step();
  endtask

  task automatic close_gate();
    i_gate = 1'b0;
    step();
    check("valid_pulse", o_valid, 1'b1);
  endtask

  initial begin
    i_reset = 1'b1; i_signal = '0; i_gate = 1'b0; i_edge_mode = 2'b00;
    idle(3);
    check("rst_count", o_count, '0);
    check("rst_valid", o_valid, 1'b0);
    i_reset = 1'b0;
    idle(4);

    // Basic rising count, 100-cycle window
    open_gate(2'b00);
    pulses(4'b0001, 10, 3, 3, 0);
    idle(39);
    close_gate();
    check("ch0_rise", o_count[W-1:0], 10);
    check("others_zero", o_count[CH*W-1:W], 0);
    check("no_ovf", o_overflow, 0);
    step();
    check("valid_one_cycle", o_valid, 1'b0);

    // Mode captured per window; mid-window changes ignored
    idle(3);
    open_gate(2'b01); pulses(4'b0001, 10, 3, 3, 1); idle(8); close_gate();
    check("ch0_fall", o_count[W-1:0], 10);
    idle(3);
    open_gate(2'b10); pulses(4'b0001, 10, 3, 3, 1); idle(8); close_gate();
    check("ch0_both", o_count[W-1:0], 20);
    idle(3);
    open_gate(2'b11); pulses(4'b0001, 10, 3, 3, 1); idle(8); close_gate();
    check("ch0_none", o_count[W-1:0], 0);

    // Saturation then clean recovery in the next window
    idle(3);
    open_gate(2'b00); pulses(4'b0001, 300, 2, 2, 0); idle(6); close_gate();
    check("sat_count", o_count[W-1:0], MAXC);
    check("sat_flag", o_overflow[0], 1'b1);
    idle(2);
    open_gate(2'b00); pulses(4'b0001, 5, 2, 2, 0); idle(6); close_gate();
    check("post_sat_count", o_count[W-1:0], 5);
    check("post_sat_flag", o_overflow[0], 1'b0);

    // Latency: rise set up before edge k counts at edge k+S
    idle(3);
    open_gate(2'b00);
    idle(4);
    i_signal[0] = 1'b1;
    for (int i = 0; i < S; i++) begin
      step();
      check("lat_early", o_live[W-1:0], 0);
    end
    step();
    check("lat_hit", o_live[W-1:0], 1);
    i_signal[0] = 1'b0;
    idle(6);
    close_gate();

    // Reset aborts a running window
    idle(3);
    open_gate(2'b00); pulses(4'b0001, 7, 2, 2, 0); idle(5);
    check("pre_rst_live", o_live[W-1:0], 7);
    i_reset = 1'b1; i_gate = 1'b0;
    step();
    check("rst_live", o_live, '0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_cnt_clear", o_count, '0);
    i_reset = 1'b0;
    idle(4);
    open_gate(2'b00); pulses(4'b0001, 4, 2, 2, 0); idle(6); close_gate();
    check("post_rst_count", o_count[W-1:0], 4);

    // Edges with the gate low are ignored; one-cycle gate-low gaps
    pulses(4'b0010, 5, 2, 2, 0);
    idle(5);
    open_gate(2'b00); pulses(4'b0010, 3, 2, 2, 0); idle(5); close_gate();
    check("gated_ch1", o_count[2*W-1:W], 3);
    i_gate = 1'b1; step();
    check("b2b_gap_valid", o_valid, 1'b0);
    close_gate();
    check("b2b_empty", o_count[2*W-1:W], 0);
    i_gate = 1'b1; step();
    pulses(4'b0010, 2, 2, 2, 0); idle(5); close_gate();
    check("b2b_ch1", o_count[2*W-1:W], 2);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      i_reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) i_gate = ~i_gate;
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 2) == 0) i_signal[c] = ~i_signal[c];
      if ($urandom_range(0, 3) == 0) i_edge_mode = 2'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_input_counter.md
# multi_input_counter

Parametrised, multi-channel successor to the single-channel gated counter. It counts qualified edges on CHANNELS asynchronous inputs during a gate window, with a configurable synchroniser depth, a selectable edge mode, saturating counters and sticky overflow flags. At the end of each gate window it latches a snapshot of all channels for the register interface. It sits between the external counter inputs and the counter register bank.

## Interface
Parameters:
- CHANNELS, 4: number of independent input channels, 1..16.
- WIDTH, 32: counter width per channel, 8..32.
- SYNC_STAGES, 2: synchroniser flops per channel, minimum 2.

Ports:
- i_clk  in  1  system clock; the only clock.
- i_reset  in  1  synchronous, active-high reset.
- i_signal  in  CHANNELS  asynchronous count inputs, bit n belongs to channel n.
- i_gate  in  1  counting window; synchronous to i_clk.
- i_edge_mode  in  2  edge qualifier: 00 rising, 01 falling, 10 both, 11 none.
- o_live  out  CHANNELS*WIDTH  running counters; channel n occupies bits [n*WIDTH +: WIDTH].
- o_count  out  CHANNELS*WIDTH  snapshot latched at gate end; same packing as o_live.
- o_overflow  out  CHANNELS  sticky saturation flags belonging to the snapshot.
- o_valid  out  1  one-cycle pulse when o_count and o_overflow update.
- o_busy  out  1  high while the block is in state RUN.

## Operation
- Synchroniser:
  - Each channel has a SYNC_STAGES-deep flop chain followed by a "prev" flop.
  - The chains run continuously; they are not gated by i_gate. Input history is therefore valid at the moment the gate opens.
- Edge detect per channel, using s = last sync stage and p = prev:
  - rise = s & ~p; fall = ~s & p.
  - The qualified edge is selected by the active mode: rise, fall, rise|fall, or 0.
- State machine, two states:
  - IDLE → RUN on the edge where i_gate is sampled 1.
    - All running counters and running overflow flags load 0 + qualified edge of that cycle.
    - i_edge_mode is captured into the active mode register.
  - RUN → RUN while i_gate = 1.
    - Each counter increments by 1 on a qualified edge.
    - i_edge_mode changes are ignored until the next window.
  - RUN → IDLE on the edge where i_gate is sampled 0. At that edge:
    - The running counters are copied to o_count and the running flags to o_overflow.
    - o_valid = 1 for exactly one cycle.
    - No increment occurs on this edge.
  - IDLE: running counters hold their values; o_live keeps showing the last window.
- Saturation:
  - A counter at 2^WIDTH-1 that receives a qualified edge stays at all-ones.
  - Its running overflow flag is set and stays set until the next window start.
- Widths: increment is +1 in WIDTH bits with saturation; the counter never wraps.
- Reset:
  - Synchroniser, prev, all counters, all flags, o_count, o_overflow, o_valid, o_busy and the active mode all go to 0. State goes to IDLE.
  - The active mode after reset is 00 (rising).
  - Reset during RUN aborts the window: no o_valid and no snapshot update.
  - i_reset has priority over every other event on the same edge.
- An input held high through reset appears as a rising edge after reset deasserts. If the gate is open by then, it is counted.

## Timing
- Input-to-count latency:
  - An i_signal change set up before edge k reaches the last sync stage after edge k+SYNC_STAGES-1.
  - It increments the counter at edge k+SYNC_STAGES, visible on o_live after that edge.
- Minimum high and low time on i_signal for guaranteed counting: 2 i_clk periods. Maximum count rate: one edge per channel per 2 cycles in mode 10.
- Gate windows:
  - o_busy rises the cycle after i_gate is sampled 1.
  - o_valid and o_count update the cycle after i_gate is sampled 0.
  - The window covers exactly the edges where i_gate = 1.
- Back-to-back windows: i_gate low for a single cycle is legal. It yields o_valid, then a new window on the following edge.
- Reset values of all outputs are 0. The first o_valid requires a complete gate window.

## Test plan
- Reset, CHANNELS=4, SYNC_STAGES=2. Open the gate for 100 cycles; drive channel 0 with 10 clean pulses of 3 high / 3 low cycles; hold other channels at 0. Close the gate → o_count ch0 = 10, others 0, o_valid high for 1 cycle, o_overflow = 0.
- Same 10 pulses, mode captured per window: window 1 mode 01 → count 10; window 2 mode 10 → count 20; window 3 mode 11 → count 0. Changing i_edge_mode mid-window has no effect.
- WIDTH=8: drive 300 rising edges in one window → o_count = 255 and o_overflow bit set. The next window with 5 edges → o_count 5 and flag clear.
- Latency check, SYNC_STAGES=3: drive i_signal rising before edge k with the gate open → o_live increments after edge k+3, not earlier.
- Assert i_reset for 1 cycle mid-window with count 7 → all outputs 0 and no o_valid. A subsequent window counts normally from 0.
- Edges arriving while the gate is low are not counted. The gate low for exactly 1 cycle between windows → two o_valid pulses 2 cycles apart, with the counts split correctly between the windows.
